// File: rtl/mp3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mp3_pkg
// Purpose  : Shared constants, state encoding and helpers for frame_sync.
// Revision : 1.0 - initial release
// ============================================================================
package mp3_pkg;

  localparam int HDR_BYTES   = 4;
  localparam int CRC_BYTES   = 2;
  localparam int SIDE_MONO   = 17;
  localparam int SIDE_STEREO = 32;
  localparam int CNT_W       = 11;

  localparam logic [1:0] MODE_MONO = 2'b11;

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    CRC  = 3'd1,
    SIDE = 3'd2,
    MAIN = 3'd3,
    HDR  = 3'd4
  } state_t;

  // Side-information length implied by the channel mode.
  function automatic logic [CNT_W-1:0] side_bytes(input logic [1:0] mode);
    return (mode == MODE_MONO) ? CNT_W'(SIDE_MONO) : CNT_W'(SIDE_STEREO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_sync.sv
`default_nettype none
// ============================================================================
// Module   : frame_sync
// Purpose  : Locks onto MPEG-1 Layer III frames, strips header/CRC and tags
//            the remaining bytes as side information or main data.
// Revision : 1.0 - initial release
// ============================================================================
module frame_sync
  import mp3_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  axiid,
  input  logic        axiiv,
  input  logic        valid_header,
  input  logic        prot,
  input  logic [1:0]  mode,
  input  logic [10:0] frame_size,
  output logic [7:0]  axiod,
  output logic        axiov,
  output logic        side_v,
  output logic        main_v,
  output logic        mono,
  output logic        frame_start,
  output logic        frame_done,
  output logic        locked,
  output logic        sync_lost
);

  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [CNT_W-1:0] r_side_len, w_side_len_nx;
  logic [CNT_W-1:0] r_main_len, w_main_len_nx;
  logic             r_mono, w_mono_nx;
  logic             r_locked, w_locked_nx;
  logic             r_side_v, w_side_v_nx;
  logic             r_main_v, w_main_v_nx;
  logic             r_frame_start, w_frame_start_nx;
  logic             r_frame_done, w_frame_done_nx;
  logic             r_sync_lost, w_sync_lost_nx;
  logic [7:0]       r_axiid_d;
  logic             r_axiiv_d;

  logic [CNT_W-1:0] w_crc_len;
  logic [CNT_W-1:0] w_hdr_side;
  logic [CNT_W-1:0] w_overhead;
  logic [CNT_W-1:0] w_cnt_dec;
  logic             w_cnt_last;
  logic             w_hdr_ok;
  logic             w_hdr_check;

  assign w_crc_len  = prot ? '0 : CNT_W'(CRC_BYTES);
  assign w_hdr_side = side_bytes(mode);
  assign w_overhead = CNT_W'(HDR_BYTES) + w_crc_len + w_hdr_side;
  // A header too short to hold its own side info is as bad as no header.
  assign w_hdr_ok   = valid_header && (frame_size >= w_overhead);
  assign w_cnt_dec  = r_cnt - CNT_W'(1);
  assign w_cnt_last = (w_cnt_dec == '0);
  assign w_hdr_check = r_axiiv_d &&
                       ((r_state == HUNT) || ((r_state == HDR) && (r_cnt == '0)));

  always_comb begin
    w_state_nx       = r_state;
    w_cnt_nx         = r_cnt;
    w_side_len_nx    = r_side_len;
    w_main_len_nx    = r_main_len;
    w_mono_nx        = r_mono;
    w_locked_nx      = r_locked;
    w_side_v_nx      = 1'b0;
    w_main_v_nx      = 1'b0;
    w_frame_start_nx = 1'b0;
    w_frame_done_nx  = 1'b0;
    w_sync_lost_nx   = 1'b0;

    case (r_state)
      HUNT, HDR: begin
        if (w_hdr_check) begin
          if (w_hdr_ok) begin
            w_mono_nx        = (mode == MODE_MONO);
            w_side_len_nx    = w_hdr_side;
            w_main_len_nx    = frame_size - w_overhead;
            w_frame_start_nx = 1'b1;
            w_locked_nx      = 1'b1;
            // The byte arriving alongside the check already belongs to the new frame.
            if (!prot) begin
              w_state_nx = CRC;
              w_cnt_nx   = axiiv ? CNT_W'(CRC_BYTES - 1) : CNT_W'(CRC_BYTES);
            end else begin
              w_state_nx  = SIDE;
              w_side_v_nx = axiiv;
              w_cnt_nx    = axiiv ? (w_hdr_side - CNT_W'(1)) : w_hdr_side;
            end
          end else if (r_state == HDR) begin
            w_sync_lost_nx = 1'b1;
            w_locked_nx    = 1'b0;
            w_state_nx     = HUNT;
            w_cnt_nx       = '0;
          end
        end else if ((r_state == HDR) && axiiv && (r_cnt != '0)) begin
          w_cnt_nx = w_cnt_dec;
        end
      end

      CRC: begin
        if (axiiv) begin
          if (w_cnt_last) begin
            w_state_nx = SIDE;
            w_cnt_nx   = r_side_len;
          end else begin
            w_cnt_nx = w_cnt_dec;
          end
        end
      end

      SIDE: begin
        if (axiiv) begin
          w_side_v_nx = 1'b1;
          if (w_cnt_last) begin
            if (r_main_len == '0) begin
              w_frame_done_nx = 1'b1;
              w_state_nx      = HDR;
              w_cnt_nx        = CNT_W'(HDR_BYTES);
            end else begin
              w_state_nx = MAIN;
              w_cnt_nx   = r_main_len;
            end
          end else begin
            w_cnt_nx = w_cnt_dec;
          end
        end
      end

      MAIN: begin
        if (axiiv) begin
          w_main_v_nx = 1'b1;
          if (w_cnt_last) begin
            w_frame_done_nx = 1'b1;
            w_state_nx      = HDR;
            w_cnt_nx        = CNT_W'(HDR_BYTES);
          end else begin
            w_cnt_nx = w_cnt_dec;
          end
        end
      end

      default: begin
        w_state_nx = HUNT;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= HUNT;
      r_cnt         <= '0;
      r_side_len    <= '0;
      r_main_len    <= '0;
      r_mono        <= 1'b0;
      r_locked      <= 1'b0;
      r_side_v      <= 1'b0;
      r_main_v      <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_sync_lost   <= 1'b0;
      r_axiid_d     <= 8'd0;
      r_axiiv_d     <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_cnt         <= w_cnt_nx;
      r_side_len    <= w_side_len_nx;
      r_main_len    <= w_main_len_nx;
      r_mono        <= w_mono_nx;
      r_locked      <= w_locked_nx;
      r_side_v      <= w_side_v_nx;
      r_main_v      <= w_main_v_nx;
      r_frame_start <= w_frame_start_nx;
      r_frame_done  <= w_frame_done_nx;
      r_sync_lost   <= w_sync_lost_nx;
      r_axiid_d     <= axiid;
      r_axiiv_d     <= axiiv;
    end
  end

  assign axiod       = r_axiid_d;
  assign side_v      = r_side_v;
  assign main_v      = r_main_v;
  assign axiov       = r_side_v | r_main_v;
  assign mono        = r_mono;
  assign frame_start = r_frame_start;
  assign frame_done  = r_frame_done;
  assign locked      = r_locked;
  assign sync_lost   = r_sync_lost;

endmodule
`default_nettype wire

// File: doc/frame_sync.md
Name: frame_sync

Overview:
- Sits directly downstream of header_finder and consumes the same byte stream that feeds it, plus its decoded header fields.
- Acquires and holds lock on MPEG-1 Layer III frame boundaries.
- Strips the 4 header bytes and the optional 2 CRC bytes.
- Emits the remaining frame bytes, each tagged as side information or main data, for the side-info parser and bit reservoir.

Parameters:
- HDR_BYTES, 4, header bytes per frame (counted inside frame_size).
- CRC_BYTES, 2, CRC bytes present when prot==0.
- SIDE_MONO, 17, side-info bytes when mode==2'b11.
- SIDE_STEREO, 32, side-info bytes for any other mode.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- axiid  in  8  stream byte (the same byte header_finder receives)
- axiiv  in  1  byte valid
- valid_header  in  1  from header_finder
- prot  in  1  from header_finder; 0 means CRC follows the header
- mode  in  2  from header_finder
- frame_size  in  11  from header_finder; total frame bytes including the header
- axiod  out  8  payload byte
- axiov  out  1  payload valid; equals side_v | main_v
- side_v  out  1  axiod is a side-info byte
- main_v  out  1  axiod is a main-data byte
- mono  out  1  latched per frame; 1 when mode==2'b11
- frame_start  out  1  one-cycle pulse when a frame is accepted
- frame_done  out  1  one-cycle pulse coincident with the last main-data byte
- locked  out  1  high while tracking frame boundaries
- sync_lost  out  1  one-cycle pulse when an expected header fails

Behaviour:
- Reset: all outputs are 0, state is HUNT, counters are 0, axiid_d/axiiv_d are 0. A reset mid-frame aborts immediately; no further tagged bytes are emitted.
- Qualified check cycle: the first cycle after an accepted byte (registered axiiv_d==1). valid_header and the header fields are sampled only in qualified cycles.
- States and transitions:
  - HUNT: no output. On a qualified cycle with valid_header==1, latch prot, mono and frame_size. Load the CRC, side and main counters: main = frame_size - HDR_BYTES - crc - side. Pulse frame_start, set locked, go to CRC (prot==0) or SIDE.
  - CRC: consume CRC_BYTES accepted bytes with no output, then go to SIDE.
  - SIDE: each accepted byte is output with side_v for side bytes; at count zero, go to MAIN.
  - MAIN: each accepted byte is output with main_v. On the last byte, pulse frame_done, clear the header counter and go to HDR.
  - HDR: consume HDR_BYTES accepted bytes with no output; they feed header_finder. In the qualified cycle after the 4th byte:
    - valid_header==1: same action as HUNT (relatch, frame_start, locked stays 1).
    - valid_header==0: pulse sync_lost, clear locked, go to HUNT.
- A byte arriving in the same cycle as a qualified check is the first post-header byte. It is routed using the newly latched fields, combinationally: counted as CRC when prot==0, otherwise output as side.
- Output latency: one cycle from axiiv/axiid to axiov/axiod; axiod is the registered byte.
- Gaps (axiiv low) stall all counters; there is no timeout.
- Sanity check in HUNT/HDR: if frame_size < HDR_BYTES + crc + side, treat the header as invalid (HUNT stays HUNT; HDR raises sync_lost).
- Arithmetic: byte counters are 11 bits, unsigned, and count down to zero; the zero-reached compare drives state transitions.

Decomposition:
- mp3_pkg holds:
  - state enum (HUNT, CRC, SIDE, MAIN, HDR)
  - the HDR_BYTES, CRC_BYTES, SIDE_MONO and SIDE_STEREO constants
  - the MODE_MONO=2'b11 localparam
- No sub-module: a single FSM plus one down-counter, around 200 lines.

Test Plan:
- Stream FF FB 90 64 followed by 413 bytes -> frame_start one cycle after 0x64; 32 side_v bytes, then 381 main_v bytes; frame_done on the last byte; mono=0; no output for header bytes.
- Stream FF FB 90 C4 followed by 413 bytes -> mono=1; 17 side bytes; 396 main bytes.
- Stream FF FA 90 64 (prot=0) followed by 413 bytes -> 2 bytes suppressed; 32 side bytes; 379 main bytes.
- Two back-to-back frames, the second FF FB 92 64 (padding, 418 bytes) -> locked stays 1; second frame_start fires; 382 main bytes.
- Frame followed by garbage 00 11 22 33 -> sync_lost pulse after the 4th garbage byte; locked=0; later FF FB 90 64 relocks.
- Random axiiv gaps and a rst asserted mid-MAIN -> byte counts unchanged under gaps; after rst, axiov=0 and locked=0 next cycle, and state is HUNT.
